// File: rtl/cluster_pkg.sv
// Shared cluster format and S-bit map geometry, common to the cluster packer and unpacker.
// Pure definitions; no latency or flow control of its own.
package cluster_pkg;
   localparam int MXSBITS    = 64;
   localparam int MXKEYS     = 192;
   localparam int MXADRBITS  = 11;
   localparam int MXCNTBITS  = 3;
   localparam int MXCLSTBITS = 14;
   localparam int MXCLUSTERS = 8;
   localparam int MXVFATS    = 24;
   localparam int MXPARTS    = 8;
   localparam int MXMAPBITS  = MXPARTS * MXKEYS;
   localparam int NULL_ADR   = 1536;
   localparam int ADR_LSB    = 0;
   localparam int CNT_LSB    = 11;

   typedef struct packed {
      logic [MXCNTBITS-1:0] cnt;
      logic [MXADRBITS-1:0] adr;
   } cluster_t;

   function automatic logic cluster_in_range(input cluster_t c);
      return c.adr < MXADRBITS'(NULL_ADR);
   endfunction
endpackage

// File: rtl/cluster_to_mask.sv
// Expands one packed cluster into its full 1536-bit hit mask; purely combinational.
// No state and no flow control; hits are clipped at the end of the cluster's eta partition.
module cluster_to_mask
   import cluster_pkg::*;
(
   input  logic [MXCLSTBITS-1:0] cluster_i,
   output logic [MXMAPBITS-1:0]  mask_o
);
   cluster_t          c;
   logic [3:0]        part;
   logic [7:0]        key;
   logic [MXKEYS-1:0] row;

   assign c    = cluster_i;
   assign part = 4'(c.adr / 11'(MXKEYS));
   assign key  = 8'(c.adr % 11'(MXKEYS));

   // row covers a single partition, so the run can never spill past key 191
   always_comb begin
      row = '0;
      for (int j = 0; j < MXKEYS; j++) begin
         if (8'(j) >= key && 8'(j) <= key + 8'(c.cnt)) row[j] = 1'b1;
      end
      mask_o = '0;
      for (int p = 0; p < MXPARTS; p++) begin
         if (cluster_in_range(c) && part == 4'(p)) mask_o[p*MXKEYS +: MXKEYS] = row;
      end
   end
endmodule

// File: rtl/cluster_unpacker.sv
// Rebuilds the 24-VFAT S-bit map from 8 packed clusters, one cluster per cycle; sbits_valid 9 cycles after accept.
// No backpressure: frames offered while busy are dropped and flagged in the sticky overflow bit.
module cluster_unpacker #(
   parameter int MXSBITS    = cluster_pkg::MXSBITS,
   parameter int MXKEYS     = cluster_pkg::MXKEYS,
   parameter int MXADRBITS  = cluster_pkg::MXADRBITS,
   parameter int MXCNTBITS  = cluster_pkg::MXCNTBITS,
   parameter int MXCLSTBITS = cluster_pkg::MXCLSTBITS,
   parameter int MXCLUSTERS = cluster_pkg::MXCLUSTERS
) (
   input  logic                  clock4x,
   input  logic                  global_reset_n,
   input  logic                  clusters_valid,
   input  logic [MXCLSTBITS-1:0] cluster0,
   input  logic [MXCLSTBITS-1:0] cluster1,
   input  logic [MXCLSTBITS-1:0] cluster2,
   input  logic [MXCLSTBITS-1:0] cluster3,
   input  logic [MXCLSTBITS-1:0] cluster4,
   input  logic [MXCLSTBITS-1:0] cluster5,
   input  logic [MXCLSTBITS-1:0] cluster6,
   input  logic [MXCLSTBITS-1:0] cluster7,
   output logic                  busy,
   output logic [MXSBITS-1:0]    vfat0,  vfat1,  vfat2,  vfat3,  vfat4,  vfat5,
   output logic [MXSBITS-1:0]    vfat6,  vfat7,  vfat8,  vfat9,  vfat10, vfat11,
   output logic [MXSBITS-1:0]    vfat12, vfat13, vfat14, vfat15, vfat16, vfat17,
   output logic [MXSBITS-1:0]    vfat18, vfat19, vfat20, vfat21, vfat22, vfat23,
   output logic                  sbits_valid,
   output logic [3:0]            n_clusters,
   output logic                  overflow
);
   import cluster_pkg::*;

   localparam int CW      = MXADRBITS + MXCNTBITS;
   localparam int MAPBITS = (24 * MXSBITS / MXKEYS) * MXKEYS;
   localparam int IW      = $clog2(MXCLUSTERS);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] EXPAND  = 2'd1;
   localparam logic [1:0] PRESENT = 2'd2;

   logic [1:0]               state_q, state_d;
   logic [MXCLUSTERS*CW-1:0] frame_q, frame_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [MAPBITS-1:0]       work_q, work_d, vfat_q, vfat_d;
   logic [3:0]               cnt_q, cnt_d, ncl_q, ncl_d;
   logic                     valid_q, valid_d, ovf_q, ovf_d;
   logic [CW-1:0]            cur;
   logic                     cur_hit;
   logic [MAPBITS-1:0]       cur_mask;

   assign cur     = frame_q[idx_q*CW +: CW];
   assign cur_hit = cur[MXADRBITS-1:0] < MXADRBITS'(NULL_ADR);

   cluster_to_mask u_mask (
      .cluster_i (cur),
      .mask_o    (cur_mask)
   );

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      idx_d   = idx_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      vfat_d  = vfat_q;
      ncl_d   = ncl_q;
      valid_d = 1'b0;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (clusters_valid) begin
               frame_d = {cluster7, cluster6, cluster5, cluster4,
                          cluster3, cluster2, cluster1, cluster0};
               work_d  = '0;
               cnt_d   = '0;
               idx_d   = '0;
               state_d = EXPAND;
            end
         end
         EXPAND: begin
            work_d = work_q | cur_mask;
            if (cur_hit) cnt_d = cnt_q + 4'd1;
            idx_d = idx_q + 1'b1;
            if (idx_q == IW'(MXCLUSTERS - 1)) state_d = PRESENT;
         end
         PRESENT: begin
            vfat_d  = work_q;
            ncl_d   = cnt_q;
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // a frame offered in any non-idle state, including the PRESENT edge, is lost
      if (clusters_valid && state_q != IDLE) ovf_d = 1'b1;
   end

   always_ff @(posedge clock4x or negedge global_reset_n) begin
      if (!global_reset_n) begin
         state_q <= IDLE;
         frame_q <= '0;
         idx_q   <= '0;
         work_q  <= '0;
         cnt_q   <= '0;
         vfat_q  <= '0;
         ncl_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         idx_q   <= idx_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         vfat_q  <= vfat_d;
         ncl_q   <= ncl_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign sbits_valid = valid_q;
   assign n_clusters  = ncl_q;
   assign overflow    = ovf_q;

   assign vfat0  = vfat_q[0*MXSBITS  +: MXSBITS];
   assign vfat1  = vfat_q[1*MXSBITS  +: MXSBITS];
   assign vfat2  = vfat_q[2*MXSBITS  +: MXSBITS];
   assign vfat3  = vfat_q[3*MXSBITS  +: MXSBITS];
   assign vfat4  = vfat_q[4*MXSBITS  +: MXSBITS];
   assign vfat5  = vfat_q[5*MXSBITS  +: MXSBITS];
   assign vfat6  = vfat_q[6*MXSBITS  +: MXSBITS];
   assign vfat7  = vfat_q[7*MXSBITS  +: MXSBITS];
   assign vfat8  = vfat_q[8*MXSBITS  +: MXSBITS];
   assign vfat9  = vfat_q[9*MXSBITS  +: MXSBITS];
   assign vfat10 = vfat_q[10*MXSBITS +: MXSBITS];
   assign vfat11 = vfat_q[11*MXSBITS +: MXSBITS];
   assign vfat12 = vfat_q[12*MXSBITS +: MXSBITS];
   assign vfat13 = vfat_q[13*MXSBITS +: MXSBITS];
   assign vfat14 = vfat_q[14*MXSBITS +: MXSBITS];
   assign vfat15 = vfat_q[15*MXSBITS +: MXSBITS];
   assign vfat16 = vfat_q[16*MXSBITS +: MXSBITS];
   assign vfat17 = vfat_q[17*MXSBITS +: MXSBITS];
   assign vfat18 = vfat_q[18*MXSBITS +: MXSBITS];
   assign vfat19 = vfat_q[19*MXSBITS +: MXSBITS];
   assign vfat20 = vfat_q[20*MXSBITS +: MXSBITS];
   assign vfat21 = vfat_q[21*MXSBITS +: MXSBITS];
   assign vfat22 = vfat_q[22*MXSBITS +: MXSBITS];
   assign vfat23 = vfat_q[23*MXSBITS +: MXSBITS];
endmodule

// File: tb/tb_cluster_unpacker.sv
// Bench for cluster_unpacker: directed literal cases plus random frames against a frame-level model.
// The model predicts outputs from partition/key arithmetic and accept/drop timing only.
module tb_cluster_unpacker;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        clusters_valid;
   logic [13:0] cl [8];
   logic        busy, sbits_valid, overflow;
   logic [3:0]  n_clusters;
   logic [63:0] vfat [24];

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   cluster_unpacker dut (
      .clock4x(clk), .global_reset_n(rst_n), .clusters_valid(clusters_valid),
      .cluster0(cl[0]), .cluster1(cl[1]), .cluster2(cl[2]), .cluster3(cl[3]),
      .cluster4(cl[4]), .cluster5(cl[5]), .cluster6(cl[6]), .cluster7(cl[7]),
      .busy(busy),
      .vfat0(vfat[0]),   .vfat1(vfat[1]),   .vfat2(vfat[2]),   .vfat3(vfat[3]),
      .vfat4(vfat[4]),   .vfat5(vfat[5]),   .vfat6(vfat[6]),   .vfat7(vfat[7]),
      .vfat8(vfat[8]),   .vfat9(vfat[9]),   .vfat10(vfat[10]), .vfat11(vfat[11]),
      .vfat12(vfat[12]), .vfat13(vfat[13]), .vfat14(vfat[14]), .vfat15(vfat[15]),
      .vfat16(vfat[16]), .vfat17(vfat[17]), .vfat18(vfat[18]), .vfat19(vfat[19]),
      .vfat20(vfat[20]), .vfat21(vfat[21]), .vfat22(vfat[22]), .vfat23(vfat[23]),
      .sbits_valid(sbits_valid), .n_clusters(n_clusters), .overflow(overflow)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   logic [1535:0] m_out, m_pend;
   int            m_ncl, m_pncl, m_due, cyc;
   bit            m_pending, m_valid, m_ovf, was_pending;

   function automatic void build(output logic [1535:0] map, output int n);
      int adr, cnt, p, k;
      map = '0;
      n   = 0;
      for (int c = 0; c < 8; c++) begin
         adr = int'(cl[c][10:0]);
         cnt = int'(cl[c][13:11]);
         if (adr < 1536) begin
            n++;
            p = adr / 192;
            k = adr % 192;
            for (int j = k; j <= k + cnt && j < 192; j++) map[p*192 + j] = 1'b1;
         end
      end
   endfunction

   initial begin
      m_out = '0; m_pend = '0; m_ncl = 0; m_pncl = 0; m_due = 0; cyc = 0;
      m_pending = 0; m_valid = 0; m_ovf = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_out = '0; m_ncl = 0; m_pending = 0; m_valid = 0; m_ovf = 0;
         end else begin
            cyc++;
            was_pending = m_pending;
            m_valid = 0;
            if (m_pending && cyc == m_due) begin
               m_out = m_pend; m_ncl = m_pncl; m_valid = 1; m_pending = 0;
            end
            if (clusters_valid) begin
               if (!was_pending) begin
                  build(m_pend, m_pncl);
                  m_pending = 1;
                  m_due = cyc + 9;
               end else begin
                  m_ovf = 1;
               end
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("sbits_valid", 64'(sbits_valid), 64'(m_valid));
         chk("busy", 64'(busy), 64'(m_pending));
         chk("overflow", 64'(overflow), 64'(m_ovf));
         chk("n_clusters", 64'(n_clusters), 64'(m_ncl));
         for (int i = 0; i < 24; i++)
            chk($sformatf("vfat%0d", i), vfat[i], m_out[i*64 +: 64]);
      end
   end

   // ---------------- stimulus ----------------
   logic [13:0] frm [8];
   int          lat, pulses;
   logic [10:0] radr;
   int          offs [9] = '{0, 60, 63, 64, 127, 128, 185, 188, 191};

   function automatic logic [13:0] mk(input int cnt, input int adr);
      return {3'(cnt), 11'(adr)};
   endfunction

   task automatic load();
      for (int i = 0; i < 8; i++) cl[i] = frm[i];
   endtask

   task automatic clear_frm();
      for (int i = 0; i < 8; i++) frm[i] = 14'h07FF;
   endtask

   task automatic wait_valid(input int start, output int l);
      l = -1;
      for (int n = start; n <= 20; n++) begin
         @(posedge clk); #1;
         if (sbits_valid) begin
            l = n;
            break;
         end
      end
   endtask

   task automatic send(input bit immediate, output int l);
      if (!immediate) begin
         @(posedge clk); #1;
      end
      load();
      clusters_valid = 1'b1;
      @(posedge clk); #1;
      clusters_valid = 1'b0;
      wait_valid(1, l);
   endtask

   task automatic rand_cluster(output logic [13:0] c);
      int r;
      r = $urandom_range(0, 9);
      if (r < 2)      radr = 11'($urandom_range(1536, 2047));
      else if (r < 5) radr = 11'(192 * $urandom_range(0, 7) + offs[$urandom_range(0, 8)]);
      else            radr = 11'($urandom_range(0, 1535));
      c = {3'($urandom_range(0, 7)), radr};
   endtask

   initial begin
      rst_n = 1'b0;
      clusters_valid = 1'b0;
      for (int i = 0; i < 8; i++) cl[i] = 14'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_overflow", 64'(overflow), 64'd0);
      chk("reset_sbits_valid", 64'(sbits_valid), 64'd0);
      chk("reset_n_clusters", 64'(n_clusters), 64'd0);
      chk("reset_vfat0", vfat[0], 64'd0);
      chk_en = 1'b1;

      // single-key cluster, accepted on the first edge after reset release
      clear_frm(); frm[0] = mk(0, 5);
      rst_n = 1'b1;
      send(1'b1, lat);
      chk("lat_first", 64'(lat), 64'd9);
      chk("single_vfat0", vfat[0], 64'h20);
      chk("single_vfat1", vfat[1], 64'h0);
      chk("single_vfat23", vfat[23], 64'h0);
      chk("single_ncl", 64'(n_clusters), 64'd1);
      @(posedge clk); #1;
      chk("single_pulse_once", 64'(sbits_valid), 64'd0);
      chk("single_hold", vfat[0], 64'h20);

      // run crossing a VFAT boundary
      clear_frm(); frm[0] = mk(7, 60);
      send(1'b0, lat);
      chk("lat_cross", 64'(lat), 64'd9);
      chk("cross_vfat0", vfat[0], 64'hF000_0000_0000_0000);
      chk("cross_vfat1", vfat[1], 64'hF);
      chk("cross_ncl", 64'(n_clusters), 64'd1);

      // run clipped at the partition end
      clear_frm(); frm[0] = mk(7, 188);
      send(1'b0, lat);
      chk("clip_vfat2", vfat[2], 64'hF000_0000_0000_0000);
      chk("clip_vfat3", vfat[3], 64'h0);
      chk("clip_vfat1", vfat[1], 64'h0);

      // one cluster at key 0 of every partition
      for (int i = 0; i < 8; i++) frm[i] = mk(0, 192 * i);
      send(1'b0, lat);
      for (int p = 0; p < 8; p++) chk($sformatf("part_vfat%0d", 3*p), vfat[3*p], 64'h1);
      chk("part_vfat1", vfat[1], 64'h0);
      chk("part_ncl", 64'(n_clusters), 64'd8);

      // second frame at T+3 dropped, frame at T+10 accepted
      clear_frm(); frm[0] = mk(2, 70);
      @(posedge clk); #1; load(); clusters_valid = 1'b1;
      @(posedge clk); #1; clusters_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      frm[0] = mk(0, 0); load(); clusters_valid = 1'b1;
      @(posedge clk); #1; clusters_valid = 1'b0;
      chk("ovf_set", 64'(overflow), 64'd1);
      wait_valid(4, lat);
      chk("lat_ovf", 64'(lat), 64'd9);
      chk("ovf_first_vfat1", vfat[1], 64'h1C0);
      chk("ovf_first_vfat0", vfat[0], 64'h0);
      frm[0] = mk(0, 1); load(); clusters_valid = 1'b1;
      @(posedge clk); #1; clusters_valid = 1'b0;
      wait_valid(1, lat);
      chk("lat_t10", 64'(lat), 64'd9);
      chk("t10_vfat0", vfat[0], 64'h2);
      chk("ovf_sticky", 64'(overflow), 64'd1);

      // reset in the middle of expansion
      clear_frm(); frm[0] = mk(0, 100);
      @(posedge clk); #1; load(); clusters_valid = 1'b1;
      @(posedge clk); #1; clusters_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_vfat0", vfat[0], 64'h0);
      chk("rst_ncl", 64'(n_clusters), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      pulses = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (sbits_valid) pulses++;
      end
      chk("rst_no_pulse", 64'(pulses), 64'd0);

      // random frames, some arriving while busy, with one reset midway
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #1;
         if (c == 300) rst_n = 1'b0;
         if (c == 302) rst_n = 1'b1;
         for (int i = 0; i < 8; i++) rand_cluster(cl[i]);
         clusters_valid = ($urandom_range(0, 3) == 0);
      end
      @(posedge clk); #1;
      clusters_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/cluster_unpacker.md
CLUSTER_UNPACKER -- requirements
Module: cluster_unpacker

Interface
REQ-001 Parameter MXSBITS, default 64, S-bits per VFAT.
REQ-002 Parameter MXKEYS, default 192, keys per eta partition (3 VFATs).
REQ-003 Parameter MXADRBITS, default 11; MXCNTBITS, default 3; MXCLSTBITS, default 14; MXCLUSTERS, default 8.
REQ-004 clock4x  input  1  sole clock; all state changes on its rising edge.
REQ-005 global_reset_n  input  1  reset, asynchronous and active-low.
REQ-006 clusters_valid  input  1  qualifies cluster0..cluster7 for one cycle.
REQ-007 cluster0..cluster7  input  14 each  packed clusters: [10:0] address, [13:11] count of additional adjacent hit pads.
REQ-008 busy  output  1  high while a frame is being expanded; low means ready to accept.
REQ-009 vfat0..vfat23  output  MXSBITS each  reconstructed S-bit map, registered.
REQ-010 sbits_valid  output  1  one-cycle pulse marking a new vfat0..vfat23 frame.
REQ-011 n_clusters  output  4  number of in-range clusters decoded in the presented frame (0-8).
REQ-012 overflow  output  1  sticky: a frame arrived while busy and was dropped.

Function
REQ-013 Address map: partition p = adr/192, key k = adr mod 192; keys 0-63 -> vfat(3p), 64-127 -> vfat(3p+1), 128-191 -> vfat(3p+2); bit = k mod 64.
REQ-014 A cluster with address >= 1536 (0x600) is empty; it sets no bits and is not counted.
REQ-015 A valid cluster sets keys k through min(k+cnt, 191) of partition p; it never spills into the next partition, but does cross VFAT boundaries within a partition.
REQ-016 FSM states: IDLE, EXPAND, PRESENT.
REQ-017 IDLE: busy=0; clusters_valid=1 latches all 8 clusters, clears the working map and cluster counter, and moves to EXPAND.
REQ-018 EXPAND: one cluster per cycle in order cluster0 first; the cluster's mask is ORed into the working map; busy=1; after cluster7 go to PRESENT.
REQ-019 PRESENT: working map copied to vfat0..vfat23, count to n_clusters, sbits_valid=1 for exactly that cycle, busy=1; next state IDLE.
REQ-020 Latency: clusters_valid accepted at cycle T -> sbits_valid high at cycle T+9; throughput one frame per 10 cycles.
REQ-021 Overlapping or duplicate clusters OR together; no error.
REQ-022 clusters_valid while busy=1 drops that frame, sets overflow, and leaves the in-progress frame untouched.
REQ-023 clusters_valid in the same cycle the FSM returns to IDLE from PRESENT is dropped as in REQ-022 (busy is still high).
REQ-024 vfat0..vfat23 and n_clusters hold their last value between sbits_valid pulses.
REQ-025 overflow clears only on reset.

Reset
REQ-026 Assertion of global_reset_n low immediately forces state IDLE; busy, sbits_valid, overflow = 0; vfat0..vfat23 = 0; n_clusters = 0; working map and latched clusters = 0.
REQ-027 Reset mid-EXPAND or mid-PRESENT abandons the frame; no sbits_valid is produced for it.
REQ-028 First frame is accepted on the first rising edge after reset deassertion.

Structure
REQ-029 MXSBITS, MXKEYS, MXADRBITS, MXCNTBITS, MXCLSTBITS, MXCLUSTERS, the null-address threshold 1536 and the address/count field positions belong in the shared package cluster_pkg, common with the packer.
REQ-030 One combinational sub-module cluster_to_mask (14-bit cluster in, 1536-bit mask out) implements REQ-013 to REQ-015; it is instantiated once and time-shared across EXPAND cycles.

Verification
REQ-031 cluster0=0x0005 (adr 5, cnt 0), others 0x07FF -> at T+9 vfat0 = 0x20, all other VFATs 0, n_clusters=1, sbits_valid pulses once.
REQ-032 cluster0 = {cnt=7, adr=60} -> vfat0 bits 60-63 and vfat1 bits 0-3 set; n_clusters=1.
REQ-033 cluster0 = {cnt=7, adr=188} -> vfat2 bits 60-63 only; vfat3 remains 0 (partition clip).
REQ-034 Eight clusters at adr 0,192,...,1344 with cnt 0 -> vfat0,3,6,...,21 bit 0 set; n_clusters=8.
REQ-035 Second clusters_valid at T+3 -> only the first frame is output at T+9, overflow=1 and stays 1; a new frame at T+10 is accepted.
REQ-036 global_reset_n low at T+4 -> busy, overflow, outputs to 0 at once; no sbits_valid at T+9.
